// File: rtl/jpeg_block_sequencer_if.sv
// Bundle for the block handshake, the pipeline drive/return buses and the result handshake.
// slave = sequencer side, master = block source / result sink / pipeline side.
interface jpeg_block_sequencer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int INPUT_WIDTH = 8,
    parameter int PIXEL_COUNT = 64,
    parameter int TAG_WIDTH   = 4
);
    localparam int PIX_W = INPUT_WIDTH * PIXEL_COUNT;
    localparam int BLK_W = DATA_WIDTH * PIXEL_COUNT;

    logic                 in_valid;
    logic                 in_ready;
    logic [TAG_WIDTH-1:0] in_tag;
    logic [PIX_W-1:0]     r_in;
    logic [PIX_W-1:0]     g_in;
    logic [PIX_W-1:0]     b_in;

    logic [PIX_W-1:0]     pipe_r;
    logic [PIX_W-1:0]     pipe_g;
    logic [PIX_W-1:0]     pipe_b;
    logic [BLK_W-1:0]     pipe_y;
    logic [BLK_W-1:0]     pipe_cb;
    logic [BLK_W-1:0]     pipe_cr;

    logic                 out_valid;
    logic                 out_ready;
    logic [BLK_W-1:0]     out_y;
    logic [BLK_W-1:0]     out_cb;
    logic [BLK_W-1:0]     out_cr;
    logic [TAG_WIDTH-1:0] out_tag;

    modport slave (
        input  in_valid, in_tag, r_in, g_in, b_in,
        input  pipe_y, pipe_cb, pipe_cr,
        input  out_ready,
        output in_ready,
        output pipe_r, pipe_g, pipe_b,
        output out_valid, out_y, out_cb, out_cr, out_tag
    );

    modport master (
        output in_valid, in_tag, r_in, g_in, b_in,
        output pipe_y, pipe_cb, pipe_cr,
        output out_ready,
        input  in_ready,
        input  pipe_r, pipe_g, pipe_b,
        input  out_valid, out_y, out_cb, out_cr, out_tag
    );
endinterface

// File: rtl/jpeg_block_sequencer.sv
// Flow-control wrapper for the free-running JPEG pipeline: registers accepted blocks onto the
// pipeline, tracks them with a token/tag shift register and buffers results in a credit-guarded FIFO.
module jpeg_block_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int INPUT_WIDTH  = 8,
    parameter int PIXEL_COUNT  = 64,
    parameter int PIPE_LATENCY = 12,
    parameter int OUT_DEPTH    = 2,
    parameter int TAG_WIDTH    = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    jpeg_block_sequencer_if.slave  bus,
    output logic                   o_busy,
    output logic [15:0]            o_blocks_done
);
    localparam int PIX_W = INPUT_WIDTH * PIXEL_COUNT;
    localparam int BLK_W = DATA_WIDTH * PIXEL_COUNT;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic [PIX_W-1:0]        r_pipe_r;
    logic [PIX_W-1:0]        r_pipe_g;
    logic [PIX_W-1:0]        r_pipe_b;
    logic [PIPE_LATENCY-1:0] r_token;
    logic [TAG_WIDTH-1:0]    r_tag [PIPE_LATENCY];

    logic [BLK_W-1:0]        r_fifo_y   [OUT_DEPTH];
    logic [BLK_W-1:0]        r_fifo_cb  [OUT_DEPTH];
    logic [BLK_W-1:0]        r_fifo_cr  [OUT_DEPTH];
    logic [TAG_WIDTH-1:0]    r_fifo_tag [OUT_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_occ;
    logic [CNT_W-1:0]        r_count;
    logic [15:0]             r_blocks_done;

    logic w_in_ready;
    logic w_accept;
    logic w_capture;
    logic w_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUT_DEPTH - 1))
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    // Credits cover in-flight plus buffered blocks, so every capture finds a free FIFO slot.
    assign w_in_ready = i_reset_n && (r_count < CNT_W'(OUT_DEPTH));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_capture  = r_token[PIPE_LATENCY-1];
    assign w_pop      = (r_occ != '0) && bus.out_ready;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pipe_r      <= '0;
            r_pipe_g      <= '0;
            r_pipe_b      <= '0;
            r_token       <= '0;
            for (int i = 0; i < PIPE_LATENCY; i++)
                r_tag[i] <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_occ         <= '0;
            r_count       <= '0;
            r_blocks_done <= '0;
        end else begin
            if (w_accept) begin
                r_pipe_r <= bus.r_in;
                r_pipe_g <= bus.g_in;
                r_pipe_b <= bus.b_in;
                r_tag[0] <= bus.in_tag;
            end
            r_token[0] <= w_accept;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                r_token[i] <= r_token[i-1];
                r_tag[i]   <= r_tag[i-1];
            end

            if (w_capture)
                r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop) begin
                r_rd_ptr      <= ptr_next(r_rd_ptr);
                r_blocks_done <= r_blocks_done + 16'd1;
            end
            r_occ   <= r_occ + CNT_W'(w_capture) - CNT_W'(w_pop);
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
        end
    end

    // Result storage needs no reset: pointers and occupancy decide what is visible.
    always_ff @(posedge i_clk) begin
        if (w_capture) begin
            r_fifo_y[r_wr_ptr]   <= bus.pipe_y;
            r_fifo_cb[r_wr_ptr]  <= bus.pipe_cb;
            r_fifo_cr[r_wr_ptr]  <= bus.pipe_cr;
            r_fifo_tag[r_wr_ptr] <= r_tag[PIPE_LATENCY-1];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.pipe_r    = r_pipe_r;
    assign bus.pipe_g    = r_pipe_g;
    assign bus.pipe_b    = r_pipe_b;
    assign bus.out_valid = (r_occ != '0);
    assign bus.out_y     = r_fifo_y[r_rd_ptr];
    assign bus.out_cb    = r_fifo_cb[r_rd_ptr];
    assign bus.out_cr    = r_fifo_cr[r_rd_ptr];
    assign bus.out_tag   = r_fifo_tag[r_rd_ptr];
    assign o_busy        = (r_count != '0);
    assign o_blocks_done = r_blocks_done;
endmodule

// File: doc/jpeg_block_sequencer.md
Name: jpeg_block_sequencer

Overview:
- Flow-control sequencer wrapped around the jpeg_compression_pipeline datapath. That datapath is free-running, with no valid and no stall.
- Accepts 8x8 RGB blocks over a valid/ready handshake and registers them onto the pipeline inputs.
- Tracks each block through the fixed pipeline latency with a token/tag shift register.
- Captures the Y/Cb/Cr zigzag results into an output FIFO with valid/ready. Credit accounting guarantees no result is ever lost under backpressure.

Parameters:
- DATA_WIDTH, 32, coefficient width of the pipeline outputs.
- INPUT_WIDTH, 8, per-component pixel width.
- PIXEL_COUNT, 64, pixels per block.
- PIPE_LATENCY, 12, cycles from a pipe_* register update to valid pipeline outputs. Must be >= 1.
- OUT_DEPTH, 2, output FIFO entries. Must be >= 1.
- TAG_WIDTH, 4, width of the user block tag carried alongside each block.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input block offered.
- in_ready  out  1  sequencer can accept a block this cycle.
- in_tag  in  TAG_WIDTH  tag travelling with the block.
- r_in, g_in, b_in  in  INPUT_WIDTH*PIXEL_COUNT each  RGB block.
- pipe_r, pipe_g, pipe_b  out  INPUT_WIDTH*PIXEL_COUNT each  registered drive to pipeline r_all/g_all/b_all.
- pipe_y, pipe_cb, pipe_cr  in  DATA_WIDTH*PIXEL_COUNT each  pipeline zigzag outputs.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_y, out_cb, out_cr  out  DATA_WIDTH*PIXEL_COUNT each  head block data.
- out_tag  out  TAG_WIDTH  head tag.
- busy  out  1  any block in flight or buffered.
- blocks_done  out  16  count of blocks popped from the FIFO; wraps at 2^16.

Behaviour:
- Reset (reset_n=0 at a clock edge), takes effect that edge:
  - pipe_r/g/b, token shift register, tag shift register, FIFO pointers, credit count and blocks_done all go to 0.
  - Outputs after reset: out_valid=0, busy=0, in_ready=0 while reset_n=0.
  - Reset mid-operation drops all in-flight and buffered blocks; no result from them appears after reset.
- Credits:
  - count = blocks in flight + FIFO occupancy, range 0..OUT_DEPTH.
  - in_ready = reset_n && (count < OUT_DEPTH). This is combinational from registered count only; it does not depend on out_ready.
- Accept: on an edge with in_valid && in_ready:
  - pipe_r/g/b <= r_in/g_in/b_in;
  - token[0] <= 1;
  - tag[0] <= in_tag.
  - Otherwise token[0] <= 0 and pipe_* hold their value.
  - One block per cycle maximum, so back-to-back accepts are legal.
- Tracking:
  - token/tag shift one stage per cycle, PIPE_LATENCY stages.
  - A block accepted at edge t has token[PIPE_LATENCY-1] set during cycle t+PIPE_LATENCY-1.
  - At edge t+PIPE_LATENCY, pipe_y/cb/cr and the tag are written into the FIFO tail.
- FIFO:
  - Circular buffer of OUT_DEPTH entries; read/write pointers wrap modulo OUT_DEPTH.
  - out_valid = occupancy != 0.
  - The head is presented combinationally from storage and is stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready; blocks_done increments on each pop.
- Simultaneous events:
  - Accept + pop in the same cycle: count unchanged.
  - Capture + pop in the same cycle: occupancy unchanged, both pointers advance.
  - Capture into a full FIFO cannot occur by construction; the bench asserts this.
  - Capture when OUT_DEPTH==1 with a same-cycle pop is legal.
- count bookkeeping: increments on accept, decrements on pop. Capture does not change count.
- busy = count != 0.
- Latency: accept edge to out_valid high is PIPE_LATENCY+1 edges; out_valid rises the cycle after the capture edge.
- Ordering: results leave in acceptance order, tags unchanged.

Test Plan (PIPE_LATENCY=4, OUT_DEPTH=2, pipeline replaced by a 4-stage delay model with y=r, cb=g, cr=b zero-extended):
- Single block, r_in all 0x10, tag 3, accepted at edge 0 → pipe_r=0x10.. after edge 0; out_valid rises after edge 4 with out_y lanes=0x10, out_tag=3; out_ready=1 gives one pop, blocks_done=1, busy=0.
- Three back-to-back offers, tags 1,2,3, out_ready=0 → tags 1,2 accepted, in_ready=0 with count=2; tag 3 held; after FIFO full, out_valid=1 with head tag 1 stable.
- From that state, pulse out_ready for one cycle → head becomes tag 2; in_ready=1 the next cycle; tag 3 accepted, then arrives 5 edges later; order 2,3 preserved.
- Streaming, in_valid=1 and out_ready=1 for 20 cycles → steady throughput limited to 2 blocks per 5 cycles by credits; no FIFO overflow assertion fires; blocks_done equals number popped.
- Reset asserted 2 cycles after accepting tag 7 → out_valid, busy and blocks_done are 0 after the reset edge; no tag-7 result appears in the following 10 cycles.
- blocks_done wrap: preload via 65536 pops (or forced) → 0xFFFF then 0x0000 on the next pop.
